// File: rtl/rpi_serial_rx.sv
// rpi_serial_rx
//   Receives MSB-first serial words clocked by a Raspberry Pi (rpi_clk/rpi_data,
//   both asynchronous to clk_in) and queues completed words in a small
//   first-word-fall-through FIFO.
//
// Ports
//   clk_in       in   system clock (only clock domain)
//   reset        in   synchronous, active-high
//   rpi_clk      in   serial clock from the Pi (async)
//   rpi_data     in   serial data, sampled on rpi_clk rising edge (async)
//   rx_enable    in   1 = receive, 0 = idle and drop any partial word
//   word_data    out  FIFO head word (0 when empty)
//   word_valid   out  FIFO non-empty
//   word_ready   in   consumer takes the head word
//   busy         out  partial word in progress
//   overflow     out  sticky: a completed word was dropped on a full FIFO
//   frame_error  out  one-cycle pulse when a stalled partial word is discarded
module rpi_serial_rx #(
    parameter int WORD_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  rpi_clk,
    input  logic                  rpi_data,
    input  logic                  rx_enable,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  busy,
    output logic                  overflow,
    output logic                  frame_error
);

    localparam int CW = $clog2(WORD_WIDTH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state;
    logic                    rpi_clk_p0, rpi_clk_p1, rpi_clk_p2;
    logic                    rpi_data_p0, rpi_data_p1;
    logic [1:0]              guard_cnt;
    logic                    rise;
    logic [WORD_WIDTH-1:0]   shift_reg;
    logic [CW-1:0]           bit_count;
    logic [TW-1:0]           tmo_cnt;
    logic                    push_pend;
    logic [WORD_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]             wr_ptr, rd_ptr;
    logic                    empty, full, pop, push_ok;

    // Synchronizer stage: p0/p1 are the 2-flop synchronizer, p2 feeds edge detect.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rpi_clk_p0  <= 1'b0;
            rpi_clk_p1  <= 1'b0;
            rpi_clk_p2  <= 1'b0;
            rpi_data_p0 <= 1'b0;
            rpi_data_p1 <= 1'b0;
        end else begin
            rpi_clk_p0  <= rpi_clk;
            rpi_clk_p1  <= rpi_clk_p0;
            rpi_clk_p2  <= rpi_clk_p1;
            rpi_data_p0 <= rpi_data;
            rpi_data_p1 <= rpi_data_p0;
        end
    end

    // The sync flops restart from 0, so a pin already high at reset release
    // would look like a rising edge; mask edges until the pipeline has refilled.
    always_ff @(posedge clk_in) begin
        if (reset)
            guard_cnt <= 2'd0;
        else if (guard_cnt != 2'd3)
            guard_cnt <= guard_cnt + 2'd1;
    end

    assign rise = rpi_clk_p1 & ~rpi_clk_p2 & (guard_cnt == 2'd3);
    assign busy = (state == SHIFT) && (bit_count != '0);

    // Deserializer stage: word assembly, timeout, push request to the FIFO.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_count   <= '0;
            tmo_cnt     <= '0;
            push_pend   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            push_pend   <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_enable)
                        state <= SHIFT;
                end
                SHIFT: begin
                    if (!rx_enable) begin
                        state     <= IDLE;
                        shift_reg <= '0;
                        bit_count <= '0;
                        tmo_cnt   <= '0;
                    end else if (rise) begin
                        tmo_cnt   <= '0;
                        shift_reg <= {shift_reg[WORD_WIDTH-2:0], rpi_data_p1};
                        if (bit_count == CW'(WORD_WIDTH - 1)) begin
                            // Completed word stays in shift_reg for the push cycle;
                            // the next rise is at least two cycles away.
                            bit_count <= '0;
                            push_pend <= 1'b1;
                        end else begin
                            bit_count <= bit_count + CW'(1);
                        end
                    end else if (busy) begin
                        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            tmo_cnt     <= '0;
                            shift_reg   <= '0;
                            bit_count   <= '0;
                            frame_error <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end else begin
                        tmo_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO stage: one extra pointer bit tells full from empty.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign word_valid = ~empty;
    assign word_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign pop        = word_valid & word_ready;
    // On a full FIFO the write slot is the head being popped this same cycle.
    assign push_ok    = push_pend & (~full | pop);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push_ok)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (push_pend && !push_ok)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= shift_reg;
    end

endmodule

// File: tb/tb_rpi_serial_rx.sv
// tb_rpi_serial_rx
//   Randomized and directed stimulus for rpi_serial_rx against a word-level
//   queue model of the receive FIFO.
module tb_rpi_serial_rx;

    localparam int W    = 16;
    localparam int D    = 4;
    localparam int HALF = 32;

    logic         clk_in = 1'b0;
    logic         reset, rpi_clk, rpi_data, rx_enable, word_ready;
    logic [W-1:0] word_data;
    logic         word_valid, busy, overflow, frame_error;

    int tests = 0;
    int fails = 0;
    int fe_pulses = 0;

    logic [W-1:0] exp_q [$];
    logic         exp_ovf = 1'b0;

    rpi_serial_rx #(.WORD_WIDTH(W), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(256)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .rpi_clk     (rpi_clk),
        .rpi_data    (rpi_data),
        .rx_enable   (rx_enable),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .busy        (busy),
        .overflow    (overflow),
        .frame_error (frame_error)
    );

    always #10 clk_in = ~clk_in;

    always @(negedge clk_in) if (frame_error) fe_pulses++;

    initial begin
        #1900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word-level model: a completed word is queued if there is room, else dropped.
    task automatic model_push(input logic [W-1:0] w);
        if (exp_q.size() < D) exp_q.push_back(w);
        else exp_ovf = 1'b1;
    endtask

    // All send tasks are entered and left exactly at a posedge time.
    task automatic send_bit(input logic b);
        #1 rpi_clk = 1'b0; rpi_data = b;
        repeat (HALF) @(posedge clk_in);
        #1 rpi_clk = 1'b1;
        repeat (HALF) @(posedge clk_in);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // Low phase plus the rising edge of one bit; returns 1 time unit after the
    // posedge that the pin change precedes.
    task automatic rise_last(input logic b);
        #1 rpi_clk = 1'b0; rpi_data = b;
        repeat (HALF) @(posedge clk_in);
        #1 rpi_clk = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            check({tag, "_valid"}, word_valid, 1);
            check({tag, "_data"}, word_data, exp_q.pop_front());
            word_ready = 1'b1;
            @(posedge clk_in);
            #1 word_ready = 1'b0;
        end
        @(negedge clk_in);
        check({tag, "_empty"}, word_valid, 0);
        @(posedge clk_in);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk_in);
        #1 reset = 1'b1;
        repeat (cycles) @(posedge clk_in);
        #1;
        check("rst_valid", word_valid, 0);
        check("rst_data", word_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_fe", frame_error, 0);
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        @(posedge clk_in);
    endtask

    initial begin
        logic [W-1:0] w;
        int n, found, fe_before;

        reset = 1'b1; rpi_clk = 1'b0; rpi_data = 1'b0;
        rx_enable = 1'b0; word_ready = 1'b0;
        do_reset(3);

        // Single word with latency check from the final rpi_clk edge.
        rx_enable = 1'b1;
        @(posedge clk_in);
        w = 16'hA5C3;
        for (int i = W - 1; i >= 1; i--) send_bit(w[i]);
        rise_last(w[0]);
        repeat (4) @(negedge clk_in);
        check("lat_valid_early", word_valid, 0);
        @(negedge clk_in);
        check("lat_valid", word_valid, 1);
        check("lat_data", word_data, 32'hA5C3);
        repeat (HALF) @(posedge clk_in);
        model_push(w);
        drain("lat_drain");

        // Random words in random-sized bursts.
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                w = W'($urandom);
                send_bits(w, W);
                model_push(w);
            end
            repeat ($urandom_range(0, 40)) @(posedge clk_in);
            check("rnd_ovf", overflow, exp_ovf);
            drain("rnd_drain");
        end

        // Five words into a four-entry FIFO with no consumer.
        for (int k = 1; k <= 5; k++) begin
            w = W'(k);
            send_bits(w, W);
            model_push(w);
        end
        check("ovf_set", overflow, exp_ovf);
        drain("ovf_drain");
        check("ovf_sticky", overflow, 1);
        do_reset(2);

        // Stalled partial word -> timeout discard, then a clean word.
        rx_enable = 1'b1;
        @(posedge clk_in);
        send_bits(W'($urandom), 7);
        #1 check("tmo_busy", busy, 1);
        n = 0; found = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk_in);
            n++;
            #1;
            if (frame_error) begin found = 1; break; end
        end
        check("tmo_fe_seen", found, 1);
        check("tmo_fe_delay", (n >= 224 && n <= 230), 1);
        check("tmo_busy_clr", busy, 0);
        @(posedge clk_in);
        #1 check("tmo_fe_pulse", frame_error, 0);
        @(posedge clk_in);
        w = W'($urandom);
        send_bits(w, W);
        model_push(w);
        drain("tmo_drain");

        // rx_enable dropped mid-word, then a full 0xFFFF word.
        fe_before = fe_pulses;
        send_bits(W'($urandom), 9);
        #1 rx_enable = 1'b0;
        repeat (5) @(posedge clk_in);
        #1 check("dis_busy", busy, 0);
        rx_enable = 1'b1;
        @(posedge clk_in);
        send_bits(16'hFFFF, W);
        model_push(16'hFFFF);
        drain("dis_drain");
        check("dis_no_fe", fe_pulses, fe_before);

        // Full FIFO, completing push coincides with a pop.
        for (int k = 0; k < D; k++) begin
            w = W'($urandom);
            send_bits(w, W);
            model_push(w);
        end
        w = W'($urandom);
        for (int i = W - 1; i >= 1; i--) send_bit(w[i]);
        rise_last(w[0]);
        repeat (3) @(posedge clk_in);
        #1 word_ready = 1'b1;
        @(posedge clk_in);
        #1 word_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(w);
        repeat (HALF) @(posedge clk_in);
        check("pp_ovf", overflow, 0);
        drain("pp_drain");

        // Reset with words buffered and rpi_clk held high.
        for (int k = 0; k < 3; k++) send_bits(W'($urandom), W);
        #1 check("stale_pre_valid", word_valid, 1);
        do_reset(3);
        repeat (12) @(posedge clk_in);
        #1;
        check("stale_busy", busy, 0);
        check("stale_valid", word_valid, 0);
        check("stale_ovf", overflow, 0);
        @(posedge clk_in);
        w = W'($urandom);
        send_bits(w, W);
        model_push(w);
        drain("post_rst_drain");

        check("fe_total", fe_pulses, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
